// File: rtl/axi4_slave_mem.sv
// rtl/axi4_slave_mem.sv - AXI4 slave with internal 32-bit word memory, FIXED/INCR bursts, SLVERR
module axi4_slave_mem #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        rst,
  input  logic        S_AXI_AWID,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic [1:0]  S_AXI_AWLOCK,
  input  logic [3:0]  S_AXI_AWCACHE,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic [3:0]  S_AXI_AWREGION,
  input  logic [3:0]  S_AXI_AWQOS,
  input  logic        S_AXI_AWUSER,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic        S_AXI_WID,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WUSER,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic        S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BUSER,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic        S_AXI_ARID,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic [1:0]  S_AXI_ARLOCK,
  input  logic [3:0]  S_AXI_ARCACHE,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic [3:0]  S_AXI_ARREGION,
  input  logic [3:0]  S_AXI_ARQOS,
  input  logic        S_AXI_ARUSER,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic        S_AXI_RID,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RUSER,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  logic [31:0] mem [DEPTH];

  // Word index relative to BASE_ADDR; the low two address bits drop out here.
  function automatic logic [29:0] word_of(input logic [31:0] addr);
    return 30'((addr - BASE_ADDR) >> 2);
  endfunction

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWREGION,
                           S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_ARLOCK, S_AXI_ARCACHE,
                           S_AXI_ARPROT, S_AXI_ARREGION, S_AXI_ARQOS, S_AXI_ARUSER,
                           S_AXI_WID, S_AXI_WUSER};
  assign S_AXI_BUSER = 1'b0;
  assign S_AXI_RUSER = 1'b0;

  // ---------------- write channel ----------------
  w_state_e    w_state_q, w_state_d;
  logic        w_id_q, w_id_d, w_bad_q, w_bad_d, w_fixed_q, w_fixed_d, w_err_q, w_err_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs, b_hs, w_last_beat, w_ok;
  logic [29:0] w_widx;

  assign aw_hs       = awready_q & S_AXI_AWVALID;
  assign w_hs        = wready_q & S_AXI_WVALID;
  assign b_hs        = bvalid_q & S_AXI_BREADY;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_widx      = word_of(w_addr_q);
  assign w_ok        = ({2'b00, w_widx} < DEPTH_W) && !w_bad_q;

  // Write FSM next state; the burst length, not WLAST, decides where the burst ends.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_bad_d   = w_bad_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_id_d    = S_AXI_AWID;
        w_addr_d  = S_AXI_AWADDR;
        w_len_d   = S_AXI_AWLEN;
        w_cnt_d   = 8'd0;
        w_bad_d   = (S_AXI_AWSIZE != 3'b010) || S_AXI_AWBURST[1];
        w_fixed_d = (S_AXI_AWBURST == 2'b00);
        w_err_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs) begin
        if (!w_ok || (S_AXI_WLAST != w_last_beat)) w_err_d = 1'b1;
        if (!w_fixed_q) w_addr_d = w_addr_q + 32'd4;
        w_cnt_d = w_cnt_q + 8'd1;
        if (w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: if (b_hs) begin
        w_err_d   = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bid_d     = bvalid_d ? w_id_d : 1'b0;
    bresp_d   = (bvalid_d && w_err_d) ? 2'b10 : 2'b00;
  end

  // Write FSM registers and registered write-channel outputs.
  always_ff @(posedge ACLK) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= 1'b0;
      w_addr_q  <= 32'd0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_bad_q   <= 1'b0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_bad_q   <= w_bad_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-strobed memory write; memory survives reset and the reset edge itself writes nothing.
  always_ff @(posedge ACLK) begin
    if (!rst && w_hs && w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_widx[AW-1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;

  // ---------------- read channel ----------------
  r_state_e    r_state_q, r_state_d;
  logic        r_id_q, r_id_d, r_bad_q, r_bad_d, r_fixed_q, r_fixed_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [7:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rid_q, rid_d, rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs, r_hs, load, rd_bad, rd_ok;
  logic [31:0] rd_addr;
  logic [29:0] rd_widx;

  assign ar_hs = arready_q & S_AXI_ARVALID;
  assign r_hs  = rvalid_q & S_AXI_RREADY;

  // Read FSM next state; the next beat is fetched on the edge that retires the current one.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_bad_d   = r_bad_q;
    r_fixed_d = r_fixed_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rd_addr   = r_addr_q;
    rd_bad    = r_bad_q;
    load      = 1'b0;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_id_d    = S_AXI_ARID;
        r_addr_d  = S_AXI_ARADDR;
        r_len_d   = S_AXI_ARLEN;
        r_cnt_d   = 8'd0;
        r_bad_d   = (S_AXI_ARSIZE != 3'b010) || S_AXI_ARBURST[1];
        r_fixed_d = (S_AXI_ARBURST == 2'b00);
        rd_addr   = S_AXI_ARADDR;
        rd_bad    = r_bad_d;
        rlast_d   = (S_AXI_ARLEN == 8'd0);
        load      = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          if (!r_fixed_q) r_addr_d = r_addr_q + 32'd4;
          r_cnt_d = r_cnt_q + 8'd1;
          rd_addr = r_addr_d;
          rlast_d = (r_cnt_d == r_len_q);
          load    = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    rd_widx = word_of(rd_addr);
    rd_ok   = ({2'b00, rd_widx} < DEPTH_W) && !rd_bad;
    if (load) begin
      rdata_d = rd_ok ? mem[rd_widx[AW-1:0]] : 32'd0;
      rresp_d = rd_ok ? 2'b00 : 2'b10;
    end
    if (r_state_d == R_IDLE) begin
      rdata_d = 32'd0;
      rresp_d = 2'b00;
      rlast_d = 1'b0;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rid_d     = rvalid_d ? r_id_d : 1'b0;
  end

  // Read FSM registers and registered read-channel outputs.
  always_ff @(posedge ACLK) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_id_q    <= 1'b0;
      r_addr_q  <= 32'd0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      r_bad_q   <= 1'b0;
      r_fixed_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_bad_q   <= r_bad_d;
      r_fixed_q <= r_fixed_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb/tb_axi4_slave_mem.sv - scoreboard bench for axi4_slave_mem
module tb_axi4_slave_mem;
  logic        ACLK = 1'b0;
  logic        rst;
  logic        S_AXI_AWID, S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_AWUSER;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic [2:0]  S_AXI_AWSIZE, S_AXI_AWPROT;
  logic [1:0]  S_AXI_AWBURST, S_AXI_AWLOCK;
  logic [3:0]  S_AXI_AWCACHE, S_AXI_AWREGION, S_AXI_AWQOS;
  logic        S_AXI_WID, S_AXI_WLAST, S_AXI_WUSER, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_BID, S_AXI_BUSER, S_AXI_BVALID, S_AXI_BREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARID, S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_ARUSER;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic [2:0]  S_AXI_ARSIZE, S_AXI_ARPROT;
  logic [1:0]  S_AXI_ARBURST, S_AXI_ARLOCK;
  logic [3:0]  S_AXI_ARCACHE, S_AXI_ARREGION, S_AXI_ARQOS;
  logic        S_AXI_RID, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;

  always #5 ACLK = ~ACLK;

  axi4_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
    .ACLK(ACLK), .rst(rst),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
    .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWREGION(S_AXI_AWREGION),
    .S_AXI_AWQOS(S_AXI_AWQOS), .S_AXI_AWUSER(S_AXI_AWUSER), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WID(S_AXI_WID), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WUSER(S_AXI_WUSER), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BUSER(S_AXI_BUSER),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(S_AXI_ARLOCK),
    .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARREGION(S_AXI_ARREGION),
    .S_AXI_ARQOS(S_AXI_ARQOS), .S_AXI_ARUSER(S_AXI_ARUSER), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RUSER(S_AXI_RUSER), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          unstable = 0;
  logic [2:0]  exp_b[$];
  logic [35:0] exp_r[$];
  logic [35:0] obs_r[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at,
                           output logic [2:0] bobs);
    int n;
    bobs = 3'bxxx;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
    S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 100) begin @(negedge ACLK); n++; end
    n_cmp++;
    if (!S_AXI_AWREADY) begin n_bad++; $display("FAIL aw_wait: AWREADY=%b want 1 within 100 cycles", S_AXI_AWREADY); end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      S_AXI_WDATA = wd[i]; S_AXI_WSTRB = ws[i]; S_AXI_WLAST = (i == last_at); S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 100) begin @(negedge ACLK); n++; end
      @(negedge ACLK);
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 100) begin @(negedge ACLK); n++; end
    if (S_AXI_BVALID) bobs = {S_AXI_BID, S_AXI_BRESP};
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int n, got, cyc;
    bit stalled;
    logic [35:0] prev;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
    S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 100) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    got = 0; cyc = 0; stalled = 1'b0; prev = '0;
    while (got <= int'(len) && cyc < 200) begin
      S_AXI_RREADY = toggle ? (cyc % 2 == 0) : 1'b1;
      if (S_AXI_RVALID) begin
        if (stalled && prev !== {S_AXI_RID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RDATA}) unstable++;
        if (S_AXI_RREADY) begin
          obs_r.push_back({S_AXI_RID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RDATA});
          got++;
          stalled = 1'b0;
        end else begin
          prev = {S_AXI_RID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RDATA};
          stalled = 1'b1;
        end
      end
      @(negedge ACLK);
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge ACLK);
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP, S_AXI_ARREADY,
         S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_BUSER, S_AXI_RUSER} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: some output nonzero (AWREADY=%b ARREADY=%b RDATA=%h) want all 0",
                        S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_RDATA);
    end
    rst = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11000) begin
      n_bad++; $display("FAIL reset_release: AW/AR/W/B/R = %b want 11000",
                        {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
  endtask

  task automatic test_single();
    logic [2:0] b, eb;
    logic [35:0] e, o;
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    exp_b.push_back({1'b1, 2'b00});
    axi_write(1'b1, 32'h40, 8'd0, 3'b010, 2'b01, 0, b);
    eb = exp_b.pop_front(); n_cmp++;
    if (b !== eb) begin n_bad++; $display("FAIL single_b: got %b want %b", b, eb); end
    exp_r.push_back({1'b1, 1'b1, 2'b00, 32'h1234_5678});
    axi_read(1'b1, 32'h40, 8'd0, 3'b010, 2'b01, 1'b0);
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); n_cmp++;
      if (obs_r.size() == 0) begin n_bad++; $display("FAIL single_r: got none want %h", e); end
      else begin o = obs_r.pop_front(); if (o !== e) begin n_bad++; $display("FAIL single_r: got %h want %h", o, e); end end
    end
    obs_r.delete();
  endtask

  task automatic test_strobe();
    logic [2:0] b, eb;
    logic [35:0] e, o;
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    exp_b.push_back({1'b0, 2'b00});
    axi_write(1'b0, 32'h40, 8'd0, 3'b010, 2'b01, 0, b);
    eb = exp_b.pop_front(); n_cmp++;
    if (b !== eb) begin n_bad++; $display("FAIL strobe_b: got %b want %b", b, eb); end
    exp_r.push_back({1'b0, 1'b1, 2'b00, 32'h12BB_56DD});
    axi_read(1'b0, 32'h40, 8'd0, 3'b010, 2'b01, 1'b0);
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); n_cmp++;
      if (obs_r.size() == 0) begin n_bad++; $display("FAIL strobe_r: got none want %h", e); end
      else begin o = obs_r.pop_front(); if (o !== e) begin n_bad++; $display("FAIL strobe_r: got %h want %h", o, e); end end
    end
    obs_r.delete();
  endtask

  task automatic test_incr();
    logic [2:0] b, eb;
    logic [35:0] e, o;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    exp_b.push_back({1'b0, 2'b00});
    axi_write(1'b0, 32'h100, 8'd3, 3'b010, 2'b01, 3, b);
    eb = exp_b.pop_front(); n_cmp++;
    if (b !== eb) begin n_bad++; $display("FAIL incr_b: got %b want %b", b, eb); end
    for (int i = 0; i < 4; i++) exp_r.push_back({1'b1, (i == 3), 2'b00, 32'(i + 1)});
    unstable = 0;
    axi_read(1'b1, 32'h100, 8'd3, 3'b010, 2'b01, 1'b1);
    n_cmp++;
    if (unstable !== 0) begin n_bad++; $display("FAIL incr_stall_hold: %0d changes while stalled want 0", unstable); end
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); n_cmp++;
      if (obs_r.size() == 0) begin n_bad++; $display("FAIL incr_r: got none want %h", e); end
      else begin o = obs_r.pop_front(); if (o !== e) begin n_bad++; $display("FAIL incr_r: got %h want %h", o, e); end end
    end
    obs_r.delete();
  endtask

  task automatic test_errors();
    logic [2:0] b, eb;
    logic [35:0] e, o;
    ws[0] = 4'hF; ws[1] = 4'hF;
    wd[0] = 32'h11;          exp_b.push_back(3'b000); axi_write(1'b0, 32'h0,   8'd0, 3'b010, 2'b01, 0, b);
    eb = exp_b.pop_front(); n_cmp++; if (b !== eb) begin n_bad++; $display("FAIL err_pre0_b: got %b want %b", b, eb); end
    wd[0] = 32'hDEAD_BEEF;   exp_b.push_back(3'b010); axi_write(1'b0, 32'h400, 8'd0, 3'b010, 2'b01, 0, b);
    eb = exp_b.pop_front(); n_cmp++; if (b !== eb) begin n_bad++; $display("FAIL err_oor_b: got %b want %b", b, eb); end
    wd[0] = 32'h77;          exp_b.push_back(3'b000); axi_write(1'b0, 32'h80,  8'd0, 3'b010, 2'b01, 0, b);
    eb = exp_b.pop_front(); n_cmp++; if (b !== eb) begin n_bad++; $display("FAIL err_pre80_b: got %b want %b", b, eb); end
    wd[0] = 32'h99; wd[1] = 32'h9A; exp_b.push_back(3'b010); axi_write(1'b0, 32'h80, 8'd1, 3'b010, 2'b10, 1, b);
    eb = exp_b.pop_front(); n_cmp++; if (b !== eb) begin n_bad++; $display("FAIL err_wrap_b: got %b want %b", b, eb); end
    wd[0] = 32'h1; wd[1] = 32'h2; exp_b.push_back(3'b110); axi_write(1'b1, 32'hC0, 8'd1, 3'b010, 2'b01, 0, b);
    eb = exp_b.pop_front(); n_cmp++; if (b !== eb) begin n_bad++; $display("FAIL err_early_last_b: got %b want %b", b, eb); end
    wd[0] = 32'h3C;          exp_b.push_back(3'b000); axi_write(1'b0, 32'h3FC, 8'd0, 3'b010, 2'b01, 0, b);
    eb = exp_b.pop_front(); n_cmp++; if (b !== eb) begin n_bad++; $display("FAIL err_pre3fc_b: got %b want %b", b, eb); end
    exp_r.push_back({1'b0, 1'b1, 2'b00, 32'h11});        axi_read(1'b0, 32'h0,   8'd0, 3'b010, 2'b01, 1'b0);
    exp_r.push_back({1'b0, 1'b1, 2'b00, 32'h77});        axi_read(1'b0, 32'h80,  8'd0, 3'b010, 2'b01, 1'b0);
    exp_r.push_back({1'b1, 1'b1, 2'b10, 32'h0});         axi_read(1'b1, 32'h400, 8'd0, 3'b010, 2'b01, 1'b0);
    exp_r.push_back({1'b0, 1'b0, 2'b00, 32'h3C});
    exp_r.push_back({1'b0, 1'b1, 2'b10, 32'h0});         axi_read(1'b0, 32'h3FC, 8'd1, 3'b010, 2'b01, 1'b0);
    exp_r.push_back({1'b0, 1'b1, 2'b10, 32'h0});         axi_read(1'b0, 32'h40,  8'd0, 3'b001, 2'b01, 1'b0);
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); n_cmp++;
      if (obs_r.size() == 0) begin n_bad++; $display("FAIL err_r: got none want %h", e); end
      else begin o = obs_r.pop_front(); if (o !== e) begin n_bad++; $display("FAIL err_r: got %h want %h", o, e); end end
    end
    obs_r.delete();
  endtask

  task automatic test_concurrent();
    logic [2:0] b, eb;
    logic [35:0] e, o;
    wd[0] = 32'd5; ws[0] = 4'hF;
    exp_b.push_back(3'b000);
    axi_write(1'b0, 32'h200, 8'd0, 3'b010, 2'b01, 0, b);
    eb = exp_b.pop_front(); n_cmp++;
    if (b !== eb) begin n_bad++; $display("FAIL conc_pre_b: got %b want %b", b, eb); end
    wd[0] = 32'd9;
    exp_b.push_back(3'b100);
    exp_r.push_back({1'b0, 1'b1, 2'b00, 32'd5});
    fork
      axi_write(1'b1, 32'h200, 8'd0, 3'b010, 2'b01, 0, b);
      axi_read(1'b0, 32'h200, 8'd0, 3'b010, 2'b01, 1'b0);
    join
    eb = exp_b.pop_front(); n_cmp++;
    if (b !== eb) begin n_bad++; $display("FAIL conc_b: got %b want %b", b, eb); end
    exp_r.push_back({1'b1, 1'b1, 2'b00, 32'd9});
    axi_read(1'b1, 32'h200, 8'd0, 3'b010, 2'b00, 1'b0);
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); n_cmp++;
      if (obs_r.size() == 0) begin n_bad++; $display("FAIL conc_r: got none want %h", e); end
      else begin o = obs_r.pop_front(); if (o !== e) begin n_bad++; $display("FAIL conc_r: got %h want %h", o, e); end end
    end
    obs_r.delete();
  endtask

  task automatic test_reset_mid();
    logic [2:0] b, eb;
    logic [35:0] e, o;
    int n;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    exp_b.push_back(3'b000);
    axi_write(1'b0, 32'h300, 8'd3, 3'b010, 2'b01, 3, b);
    eb = exp_b.pop_front(); n_cmp++;
    if (b !== eb) begin n_bad++; $display("FAIL rstmid_pre_b: got %b want %b", b, eb); end
    S_AXI_AWID = 1'b1; S_AXI_AWADDR = 32'h300; S_AXI_AWLEN = 8'd3;
    S_AXI_AWSIZE = 3'b010; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 100) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      S_AXI_WDATA = 32'hB0 + 32'(i); S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 100) begin @(negedge ACLK); n++; end
      @(negedge ACLK);
    end
    S_AXI_WVALID = 1'b0;
    rst = 1'b1;
    @(negedge ACLK);
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP, S_AXI_ARREADY,
         S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: AWREADY=%b WREADY=%b BVALID=%b ARREADY=%b want all 0",
                        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY);
    end
    rst = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b100) begin
      n_bad++; $display("FAIL rstmid_release: AWREADY/WREADY/BVALID = %b want 100",
                        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
    end
    exp_r.push_back({1'b0, 1'b0, 2'b00, 32'hB0});
    exp_r.push_back({1'b0, 1'b0, 2'b00, 32'hB1});
    exp_r.push_back({1'b0, 1'b0, 2'b00, 32'hA2});
    exp_r.push_back({1'b0, 1'b1, 2'b00, 32'hA3});
    axi_read(1'b0, 32'h300, 8'd3, 3'b010, 2'b01, 1'b0);
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); n_cmp++;
      if (obs_r.size() == 0) begin n_bad++; $display("FAIL rstmid_r: got none want %h", e); end
      else begin o = obs_r.pop_front(); if (o !== e) begin n_bad++; $display("FAIL rstmid_r: got %h want %h", o, e); end end
    end
    obs_r.delete();
  endtask

  initial begin
    rst = 1'b1;
    S_AXI_AWID = 0; S_AXI_AWADDR = 0; S_AXI_AWLEN = 0; S_AXI_AWSIZE = 3'b010; S_AXI_AWBURST = 2'b01;
    S_AXI_AWLOCK = 0; S_AXI_AWCACHE = 0; S_AXI_AWPROT = 0; S_AXI_AWREGION = 0; S_AXI_AWQOS = 0;
    S_AXI_AWUSER = 0; S_AXI_AWVALID = 0;
    S_AXI_WID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WLAST = 0; S_AXI_WUSER = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0;
    S_AXI_ARID = 0; S_AXI_ARADDR = 0; S_AXI_ARLEN = 0; S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01;
    S_AXI_ARLOCK = 0; S_AXI_ARCACHE = 0; S_AXI_ARPROT = 0; S_AXI_ARREGION = 0; S_AXI_ARQOS = 0;
    S_AXI_ARUSER = 0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 0;
    test_reset();
    test_single();
    test_strobe();
    test_incr();
    test_errors();
    test_concurrent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
